jag_prescaler_bank: RTL and testbench
=====================================

# jag_prescaler_bank

Parametrised bank of independent reloadable down-counting prescalers for the UART/timer area of the Jaguar I/O block. It generalises the single 16-bit UART2 prescaler to CHANNELS channels of WIDTH bits, each with enable, continuous or one-shot mode, a per-channel tick pulse and sticky clear-on-read tick status. Register access uses the usual din / dr_out / dr_oe pattern; everything runs on sys_clk with a count-enable qualifier in place of a secondary clock.

## Interface
- WIDTH, 16, counter/divisor/data width; must be >= 2*CHANNELS
- CHANNELS, 4, number of prescaler channels (1..8)
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= CHANNELS+2
- sys_clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- cnt_en  in  1  count qualifier; one decrement per channel per sys_clk with cnt_en=1
- addr  in  ADDR_W  register select
- din  in  WIDTH  write data
- wr  in  1  register write strobe, one sys_clk per access
- rd  in  1  register read strobe, one sys_clk per access
- dr_out  out  WIDTH  read data, combinational from addr
- dr_oe  out  1  read-data output enable, equal to rd
- tick  out  CHANNELS  per-channel one-cycle terminal pulse, registered

## Operation
- Register map: addr 0..CHANNELS-1 holds DIV[n] (write) and returns CNT[n] (read). addr CHANNELS is CTRL (R/W): bits [CHANNELS-1:0] are EN, bits [2*CHANNELS-1:CHANNELS] are ONESHOT, upper bits read 0. addr CHANNELS+1 is STAT (read, clear-on-read): bits [CHANNELS-1:0] are sticky tick flags. Other addresses read 0 and ignore writes.
- A channel is active when EN[n]=1 and DIV[n]!=0. DIV=0 forces CNT=0, emits no tick and holds the channel idle. The EN bit stays as written.
- Writing DIV[n] loads CNT[n] := din on the next edge. In that cycle the write wins over decrement and tick.
- A 0->1 transition of EN[n] through a CTRL write loads CNT[n] := DIV[n]. A 1->0 transition freezes CNT[n].
- Active channel with cnt_en=1:
  - if CNT!=0, CNT := CNT-1
  - if CNT==0, CNT := DIV, tick[n]=1 on the next cycle, and STAT[n] is set
- Tick period is therefore DIV+1 cnt_en cycles.
- If ONESHOT[n]=1, the terminal event also clears EN[n] in the same edge. CNT is reloaded with DIV, and the channel then stays idle.
- Arithmetic is unsigned, modulo 2^WIDTH. There is no wrap below zero because reload happens at zero.
- Read of STAT clears the flags that are returned. A flag set in the same cycle as the read is kept for the next read.
- A CTRL write in the same cycle as a one-shot terminal event: the written EN value wins.

## Timing
- Reset (edge with reset=1): DIV, CNT, CTRL, STAT and tick all 0. dr_out then reads 0 at every address.
- Reset overrides wr, rd and cnt_en in the same cycle. Reset mid-count aborts with no tick.
- Write latency is 1 sys_clk: the register value is visible on dr_out in the cycle after wr.
- Read latency is 0: dr_out and dr_oe are valid in the rd cycle. Clear-on-read takes effect at that edge.
- tick[n] is high for exactly one sys_clk, the cycle after the edge that reloads CNT from 0. Consecutive ticks are possible when DIV=1 and cnt_en is held high (period 2).
- Channels are fully independent; simultaneous terminal events on several channels all tick in the same cycle.

## Test plan
- Reset, then read every address -> all return 0. Then DIV0=3, EN0=1, cnt_en held 1 -> CNT0 reads 3,2,1,0,3; tick[0] pulses every 4 cycles; STAT=0x0001 then reads 0x0000.
- Channel 1 with DIV1=2 and ONESHOT1=1, EN1=1 -> one tick[1] after 3 counts. CTRL then reads EN1=0, ONESHOT1=1, and CNT1 stays at 2.
- Set DIV2=0 with EN2=1 -> no tick, CNT2=0. Then write DIV2=5 in a cycle with cnt_en=1 and CNT2 already 0 -> CNT2=5 next cycle and no tick.
- Channel 0 running with DIV0=4; clear EN0 at CNT0=2 and hold 10 cycles -> CNT0 stays 2. Set EN0 again -> CNT0 reloads 4.
- cnt_en toggled 1/0 every cycle with DIV3=1 -> tick[3] every 4 sys_clk.
- Assert reset while CNT0=1 and STAT is nonzero -> no tick, all registers read 0 the next cycle.

Source files
------------

// File: rtl/jag_prescaler_bank_if.sv
// Register-access bus for jag_prescaler_bank.
// Uses the din / dr_out / dr_oe pattern: one write or read strobe per sys_clk.
//   addr   : register select
//   din    : write data
//   wr, rd : single-cycle access strobes
//   dr_out : read data, combinational from addr
//   dr_oe  : read-data output enable (follows rd)
// Modports: master drives the bus (CPU side), slave is the register bank.
interface jag_prescaler_bank_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  din;
  logic              wr;
  logic              rd;
  logic [WIDTH-1:0]  dr_out;
  logic              dr_oe;

  modport master (output addr, din, wr, rd, input dr_out, dr_oe);
  modport slave  (input addr, din, wr, rd, output dr_out, dr_oe);
endinterface

// File: rtl/jag_prescaler_bank.sv
// Bank of CHANNELS independent reloadable down-counting prescalers.
// Each channel counts DIV..0 on cnt_en, reloads from DIV at zero, pulses
// tick[n] for one cycle and sets a sticky STAT flag. ONESHOT channels clear
// their own EN bit on the terminal event.
// Ports:
//   sys_clk : single clock, all state changes on its rising edge
//   reset   : synchronous, active-high
//   cnt_en  : count qualifier, one decrement per channel per qualified clock
//   bus     : register access (slave modport of jag_prescaler_bank_if)
//   tick    : per-channel one-cycle terminal pulse, registered
// Register map:
//   0..CHANNELS-1 : write DIV[n] (also loads CNT[n]), read CNT[n]
//   CHANNELS      : CTRL, [CHANNELS-1:0] EN, [2*CHANNELS-1:CHANNELS] ONESHOT
//   CHANNELS+1    : STAT, sticky tick flags, clear-on-read
//   others        : read 0, writes ignored
module jag_prescaler_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                cnt_en,
  jag_prescaler_bank_if.slave bus,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(CHANNELS + 1);

  logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]            en_q, en_d;
  logic [CHANNELS-1:0]            os_q, os_d;
  logic [CHANNELS-1:0]            stat_q, stat_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;

  logic                ctrl_wr;
  logic                stat_rd;
  logic [CHANNELS-1:0] run;
  logic [CHANNELS-1:0] stat_set;
  logic [WIDTH-1:0]    rdata;

  assign ctrl_wr = bus.wr && (bus.addr == CTRL_ADDR);
  assign stat_rd = bus.rd && (bus.addr == STAT_ADDR);

  // A CTRL write that drops EN freezes the count at this very edge, so the
  // channel does not take one last decrement on its way out.
  always_comb begin
    run = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      run[n] = en_q[n] && !(ctrl_wr && !bus.din[n]) && (div_q[n] != '0);
    end
  end

  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    os_d     = os_q;
    tick_d   = '0;
    stat_set = '0;

    if (ctrl_wr) begin
      en_d = bus.din[CHANNELS-1:0];
      os_d = bus.din[2*CHANNELS-1:CHANNELS];
    end

    for (int n = 0; n < CHANNELS; n++) begin
      if (bus.wr && (bus.addr == ADDR_W'(n))) begin
        div_d[n] = bus.din;
        cnt_d[n] = bus.din;
      end else if (ctrl_wr && bus.din[n] && !en_q[n]) begin
        cnt_d[n] = div_q[n];
      end else if (run[n] && cnt_en) begin
        if (cnt_q[n] == '0) begin
          cnt_d[n]    = div_q[n];
          tick_d[n]   = 1'b1;
          stat_set[n] = 1'b1;
          // A simultaneous CTRL write owns EN, so the one-shot clear yields.
          if (os_q[n] && !ctrl_wr) begin
            en_d[n] = 1'b0;
          end
        end else begin
          cnt_d[n] = cnt_q[n] - WIDTH'(1);
        end
      end
    end

    // Flags set at the reading edge survive for the next read.
    stat_d = stat_rd ? stat_set : (stat_q | stat_set);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_q  <= '0;
      cnt_q  <= '0;
      en_q   <= '0;
      os_q   <= '0;
      stat_q <= '0;
      tick_q <= '0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      os_q   <= os_d;
      stat_q <= stat_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (bus.addr == ADDR_W'(n)) begin
        rdata = cnt_q[n];
      end
    end
    if (bus.addr == CTRL_ADDR) begin
      rdata[CHANNELS-1:0]          = en_q;
      rdata[2*CHANNELS-1:CHANNELS] = os_q;
    end
    if (bus.addr == STAT_ADDR) begin
      rdata[CHANNELS-1:0] = stat_q;
    end
  end

  assign bus.dr_out = rdata;
  assign bus.dr_oe  = bus.rd;
  assign tick       = tick_q;

endmodule

// File: tb/tb_jag_prescaler_bank.sv
module tb_jag_prescaler_bank;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [15:0] din;
    logic        cen;
    logic        chk_dr;
    logic [15:0] exp_dr;
    logic        chk_tk;
    logic [3:0]  exp_tk;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       cnt_en  = 1'b0;
  logic [3:0] tick;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[$];

  jag_prescaler_bank_if #(.WIDTH(16), .ADDR_W(4)) bus ();

  jag_prescaler_bank #(.WIDTH(16), .CHANNELS(4), .ADDR_W(4)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .cnt_en  (cnt_en),
    .bus     (bus),
    .tick    (tick)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic void row(logic rst, logic wr, logic rd, logic [3:0] a, logic [15:0] d,
                              logic cen, logic cdr, logic [15:0] edr, logic ctk, logic [3:0] etk);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.addr = a; v.din = d; v.cen = cen;
    v.chk_dr = cdr; v.exp_dr = edr; v.chk_tk = ctk; v.exp_tk = etk;
    vecs.push_back(v);
  endfunction

  function automatic void rrd(logic [3:0] a, logic cen, logic [15:0] edr, logic [3:0] etk);
    row(1'b0, 1'b0, 1'b1, a, 16'h0, cen, 1'b1, edr, 1'b1, etk);
  endfunction

  function automatic void rwr(logic [3:0] a, logic [15:0] d, logic cen, logic [3:0] etk);
    row(1'b0, 1'b1, 1'b0, a, d, cen, 1'b0, 16'h0, 1'b1, etk);
  endfunction

  task automatic drive(input logic rst, input logic wr, input logic rd, input logic [3:0] a,
                       input logic [15:0] d, input logic cen);
    @(negedge sys_clk);
    reset    = rst;
    bus.wr   = wr;
    bus.rd   = rd;
    bus.addr = a;
    bus.din  = d;
    cnt_en   = cen;
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.din = '0;

    // Reset and read every address
    row(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    row(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b1, 4'h0);
    for (int a = 0; a < 8; a++) rrd(4'(a), 1'b0, 16'h0, 4'h0);

    // Channel 0, DIV=3, continuous
    rwr(4'd0, 16'd3, 1'b0, 4'h0);
    rwr(4'd4, 16'h0001, 1'b0, 4'h0);
    rrd(4'd0, 1'b1, 16'd3, 4'h0);
    rrd(4'd0, 1'b1, 16'd2, 4'h0);
    rrd(4'd0, 1'b1, 16'd1, 4'h0);
    rrd(4'd0, 1'b1, 16'd0, 4'h0);
    rrd(4'd0, 1'b1, 16'd3, 4'h1);
    rrd(4'd0, 1'b1, 16'd2, 4'h0);
    rrd(4'd0, 1'b1, 16'd1, 4'h0);
    rrd(4'd0, 1'b1, 16'd0, 4'h0);
    rrd(4'd0, 1'b1, 16'd3, 4'h1);
    rrd(4'd5, 1'b0, 16'h0001, 4'h0);
    rrd(4'd5, 1'b0, 16'h0000, 4'h0);

    // Channel 1 one-shot, DIV=2 (this CTRL write also stops channel 0 at CNT=2)
    rwr(4'd1, 16'd2, 1'b0, 4'h0);
    rwr(4'd4, 16'h0022, 1'b0, 4'h0);
    rrd(4'd1, 1'b1, 16'd2, 4'h0);
    rrd(4'd1, 1'b1, 16'd1, 4'h0);
    rrd(4'd1, 1'b1, 16'd0, 4'h0);
    rrd(4'd1, 1'b1, 16'd2, 4'h2);
    rrd(4'd4, 1'b1, 16'h0020, 4'h0);
    rrd(4'd1, 1'b1, 16'd2, 4'h0);
    rrd(4'd0, 1'b1, 16'd2, 4'h0);
    rrd(4'd5, 1'b0, 16'h0002, 4'h0);

    // Channel 2 with DIV=0 stays idle; DIV write then loads CNT without tick
    rwr(4'd4, 16'h0004, 1'b1, 4'h0);
    rrd(4'd2, 1'b1, 16'd0, 4'h0);
    rrd(4'd2, 1'b1, 16'd0, 4'h0);
    rrd(4'd2, 1'b1, 16'd0, 4'h0);
    rrd(4'd5, 1'b1, 16'h0000, 4'h0);
    rwr(4'd2, 16'd5, 1'b1, 4'h0);
    rrd(4'd2, 1'b0, 16'd5, 4'h0);
    rrd(4'd5, 1'b0, 16'h0000, 4'h0);
    rwr(4'd4, 16'h0000, 1'b0, 4'h0);

    // Channel 0, DIV=4: freeze at CNT=2 for 10 cycles, re-enable reloads DIV
    rwr(4'd0, 16'd4, 1'b0, 4'h0);
    rwr(4'd4, 16'h0001, 1'b0, 4'h0);
    rrd(4'd0, 1'b1, 16'd4, 4'h0);
    rrd(4'd0, 1'b1, 16'd3, 4'h0);
    row(1'b0, 1'b1, 1'b0, 4'd4, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b1, 4'h0);
    for (int k = 0; k < 10; k++) rrd(4'd0, 1'b1, 16'd2, 4'h0);
    rwr(4'd4, 16'h0001, 1'b1, 4'h0);
    rrd(4'd0, 1'b0, 16'd4, 4'h0);

    // Channel 3, DIV=1, cnt_en alternating: tick every 4 sys_clk
    rwr(4'd3, 16'd1, 1'b0, 4'h0);
    rwr(4'd4, 16'h0008, 1'b0, 4'h0);
    for (int k = 0; k < 12; k++)
      rrd(4'd3, (k % 2) == 0, ((k % 4) == 0 || (k % 4) == 3) ? 16'd1 : 16'd0,
          ((k % 4) == 3) ? 4'h8 : 4'h0);

    // Reset mid-count with STAT[3] pending and channel 0 about to tick
    rwr(4'd4, 16'h0001, 1'b0, 4'h0);
    rrd(4'd0, 1'b1, 16'd4, 4'h0);
    rrd(4'd0, 1'b1, 16'd3, 4'h0);
    rrd(4'd0, 1'b1, 16'd2, 4'h0);
    rrd(4'd0, 1'b1, 16'd1, 4'h0);
    row(1'b1, 1'b0, 1'b1, 4'd0, 16'h0, 1'b1, 1'b1, 16'd0, 1'b1, 4'h0);
    for (int a = 0; a < 8; a++) rrd(4'(a), 1'b0, 16'h0, 4'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, vecs[i].cen);
      if (vecs[i].chk_dr) begin
        chk($sformatf("row%0d dr_out", i), bus.dr_out, vecs[i].exp_dr);
        chk($sformatf("row%0d dr_oe", i), {15'b0, bus.dr_oe}, {15'b0, vecs[i].rd});
      end
      if (vecs[i].chk_tk)
        chk($sformatf("row%0d tick", i), {12'b0, tick}, {12'b0, vecs[i].exp_tk});
    end

    // DIV=1 with cnt_en held: back-to-back ticks, STAT read racing a set
    drive(1'b0, 1'b1, 1'b0, 4'd1, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd4, 16'h0002, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    chk("h1 tick", {12'b0, tick}, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 1'b1);
    chk("h2 stat", bus.dr_out, 16'h0000);
    chk("h2 tick", {12'b0, tick}, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 1'b1);
    chk("h3 stat kept", bus.dr_out, 16'h0002);
    chk("h3 tick", {12'b0, tick}, 16'h2);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    chk("h4 tick", {12'b0, tick}, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    chk("h5 tick", {12'b0, tick}, 16'h2);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 1'b0);
    chk("h6 tick", {12'b0, tick}, 16'h0);
    chk("h6 stat", bus.dr_out, 16'h0002);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 1'b0);
    chk("h7 stat cleared", bus.dr_out, 16'h0000);

    // One-shot terminal event colliding with a CTRL write: written EN wins
    drive(1'b0, 1'b1, 1'b0, 4'd2, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd4, 16'h0044, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 4'd4, 16'h0044, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 4'd4, 16'h0, 1'b1);
    chk("os race ctrl", bus.dr_out, 16'h0044);
    chk("os race tick", {12'b0, tick}, 16'h4);
    drive(1'b0, 1'b0, 1'b1, 4'd4, 16'h0, 1'b1);
    chk("os count tick", {12'b0, tick}, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 4'd4, 16'h0, 1'b0);
    chk("os done ctrl", bus.dr_out, 16'h0040);
    chk("os done tick", {12'b0, tick}, 16'h4);
    drive(1'b0, 1'b0, 1'b1, 4'd2, 16'h0, 1'b0);
    chk("os done cnt", bus.dr_out, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
